hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W) with no data forwarding.
- Detects RAW dependences of the Decode-stage sources on pending writes in Execute and Memory.
- Stalls Fetch/Decode and inserts an Execute bubble while a dependence exists.
- Flushes wrong-path instructions when a branch or jump resolves taken in Execute.
- Mostly combinational; one internal register tracks whether the Memory-stage instruction writes the register file.

Parameters:
- REG_WIDTH, 5, width of register-file indices (32 architectural registers).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- regwriteE  input  1  Execute-stage instruction writes register file.
- Rs1D  input  REG_WIDTH  Decode-stage source register 1.
- Rs2D  input  REG_WIDTH  Decode-stage source register 2.
- RdE  input  REG_WIDTH  Execute-stage destination register.
- RdM  input  REG_WIDTH  Memory-stage destination register.
- PCSrcE  input  1  taken branch/jump resolved in Execute.
- stallF  output  1  hold PC register.
- flushF  output  1  discard the instruction being fetched.
- stallD  output  1  hold IF/ID register.
- flushD  output  1  clear IF/ID register (insert NOP).
- flushE  output  1  clear ID/EX register (insert bubble).

Behaviour:
- Internal state regwriteM_q: on each rising clk, if rst then 0, else regwriteE. Represents the write-enable of the instruction now in Memory (the E-stage instruction always advances; a bubble enters with regwriteE=0).
- hazE = regwriteE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- hazM = regwriteM_q & (RdM != 0) & ((RdM == Rs1D) | (RdM == Rs2D)).
- Register x0 never causes a hazard. RdE is ignored when regwriteE=0; RdM is ignored when regwriteM_q=0, including X/undriven values.
- Rs1D == Rs2D matching a destination is a single hazard; there is no double counting.
- stall = (hazE | hazM) & ~PCSrcE. A taken branch overrides the stall because the D-stage instruction is wrong-path.
- stallF = stallD = stall.
- flushF = PCSrcE; flushD = PCSrcE.
- flushE = stall | PCSrcE.
- All outputs are combinational functions of the current inputs and regwriteM_q. They settle in the same cycle with zero latency and no handshake.
- While rst = 1, every output is forced to 0 regardless of inputs. After rst deasserts, regwriteM_q = 0 until the first post-reset edge, so the first cycle can only stall via hazE or flush via PCSrcE.
- Stall duration without forwarding: a dependence on E stalls 2 cycles (hazE, then hazM). A dependence only on M stalls 1 cycle. Writeback is assumed to write in the first half-cycle, so W is not checked.
- PCSrcE together with a hazard: flushF = flushD = flushE = 1, stallF = stallD = 0.
- No output ever has stallD = 1 and flushD = 1 simultaneously.

Test Plan:
- Reset: rst=1 with regwriteE=1, Rs1D=RdE=2, PCSrcE=1 -> all outputs 0. Release rst -> regwriteM_q=0 after the next edge.
- E hazard: regwriteE=1, Rs1D=2, Rs2D=3, RdE=2, PCSrcE=0 -> stallF=stallD=flushE=1, flushF=flushD=0. Hold for 1 edge with RdM=2 -> still stalled via hazM.
- No-write / x0: regwriteE=0, Rs1D=RdE=2, regwriteM_q=0 -> stall=0. Also regwriteE=1, Rs1D=RdE=0 -> stall=0.
- Branch priority: regwriteE=0, Rs1D=Rs2D=RdE=2, PCSrcE=1 -> flushF=flushD=flushE=1, stallF=stallD=0. Repeat with regwriteE=1 -> same result.
- M hazard: regwriteE=1 for one edge, then regwriteE=0, Rs1D=5, Rs2D=3, RdM=5, RdE=9 -> stallF=stallD=flushE=1. Then regwriteE=0 held for 1 more edge -> all outputs 0.
- Rs2 match, dual sources: regwriteE=1 for one edge, then regwriteE=1, Rs1D=Rs2D=7, RdM=7, RdE=0 -> stall=1 via hazM only. Set PCSrcE=1 -> stall=0, all flushes 1.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard-controller signal bundle: Decode/Execute/Memory status in,
// stall and flush controls out. The pipeline drives through "master";
// the hazard unit attaches through "slave".
interface hazard_unit_if #(
  parameter int REG_WIDTH = 5
);
  logic                 regwriteE;
  logic [REG_WIDTH-1:0] Rs1D;
  logic [REG_WIDTH-1:0] Rs2D;
  logic [REG_WIDTH-1:0] RdE;
  logic [REG_WIDTH-1:0] RdM;
  logic                 PCSrcE;
  logic                 stallF;
  logic                 flushF;
  logic                 stallD;
  logic                 flushD;
  logic                 flushE;

  modport master (
    output regwriteE, Rs1D, Rs2D, RdE, RdM, PCSrcE,
    input  stallF, flushF, stallD, flushD, flushE
  );

  modport slave (
    input  regwriteE, Rs1D, Rs2D, RdE, RdM, PCSrcE,
    output stallF, flushF, stallD, flushD, flushE
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for a 5-stage RV32I pipeline without forwarding.
// A Decode source that matches a pending write in Execute or Memory holds
// F/D and drops a bubble into E; a taken branch/jump in Execute flushes the
// wrong-path F and D instructions and wins over any stall.
module hazard_unit #(
  parameter int REG_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  // Write-enable of the instruction currently in Memory. Execute always
  // advances (a bubble carries regwriteE=0), so this is regwriteE delayed.
  logic regwriteM_q;

  logic haz_e;
  logic haz_m;
  logic stall;

  // True when a pending write to rd feeds either Decode source; x0 is a
  // constant and never creates a dependence. Rs1D==Rs2D collapses to one hit.
  function automatic logic raw_hit(
    input logic                 we,
    input logic [REG_WIDTH-1:0] rd,
    input logic [REG_WIDTH-1:0] rs1,
    input logic [REG_WIDTH-1:0] rs2
  );
    logic hit;
    hit = 1'b0;
    // Gate on we first so an undriven rd of a non-writing instruction
    // cannot leak into the result.
    if (we) begin
      hit = (rd != '0) && ((rd == rs1) || (rd == rs2));
    end
    return hit;
  endfunction

  // Track the Memory-stage write-enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwriteM_q <= 1'b0;
    end else begin
      regwriteM_q <= hz.regwriteE;
    end
  end

  // Dependence detection and stall/flush generation; reset silences all.
  always_comb begin
    haz_e     = 1'b0;
    haz_m     = 1'b0;
    stall     = 1'b0;
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.flushF = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    if (!rst) begin
      haz_e = raw_hit(hz.regwriteE, hz.RdE, hz.Rs1D, hz.Rs2D);
      haz_m = raw_hit(regwriteM_q,  hz.RdM, hz.Rs1D, hz.Rs2D);
      // The Decode instruction is wrong-path on a taken branch, so there is
      // nothing worth stalling for; this also keeps stallD and flushD apart.
      stall     = (haz_e || haz_m) && !hz.PCSrcE;
      hz.stallF = stall;
      hz.stallD = stall;
      hz.flushF = hz.PCSrcE;
      hz.flushD = hz.PCSrcE;
      hz.flushE = stall || hz.PCSrcE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Outputs are packed as
// {stallF, flushF, stallD, flushD, flushE} for compact expected values.
module tb_hazard_unit;

  localparam int RW = 5;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b10101;
  localparam logic [4:0] FLUSH = 5'b01011;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  hazard_unit_if #(.REG_WIDTH(RW)) hif ();

  hazard_unit #(.REG_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {hif.stallF, hif.flushF, hif.stallD, hif.flushD, hif.flushE};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Let inputs settle, then check the packed outputs and the
  // never-stall-and-flush-D-together invariant.
  task automatic chk_outs(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, 32'(outs()), 32'(exp));
    chk({tag, "_sd_fd"}, 32'(hif.stallD & hif.flushD), 32'd0);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rde, input logic [RW-1:0] rdm, input logic pcs);
    hif.regwriteE = we;
    hif.Rs1D      = rs1;
    hif.Rs2D      = rs2;
    hif.RdE       = rde;
    hif.RdM       = rdm;
    hif.PCSrcE    = pcs;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // Reset dominates a hazard and a taken branch.
    rst = 1'b1;
    drive(1'b1, 5'd2, 5'd3, 5'd2, 5'd0, 1'b1);
    chk_outs("rst_outs", NONE);
    edge_step();
    edge_step();
    chk_outs("rst_outs_held", NONE);
    chk("rst_regwriteM", 32'(dut.regwriteM_q), 32'd0);

    // Release: Memory write-enable still clear, so RdM match is ignored.
    rst = 1'b0;
    drive(1'b0, 5'd2, 5'd3, 5'd2, 5'd2, 1'b0);
    chk_outs("post_rst_no_hazm", NONE);
    edge_step();
    chk("post_rst_regwriteM", 32'(dut.regwriteM_q), 32'd0);

    // Execute hazard on Rs1, then the same producer seen in Memory.
    drive(1'b1, 5'd2, 5'd3, 5'd2, 5'd0, 1'b0);
    chk_outs("haz_e_rs1", STALL);
    edge_step();
    chk("regwriteM_follows", 32'(dut.regwriteM_q), 32'd1);
    drive(1'b0, 5'd2, 5'd3, 5'd0, 5'd2, 1'b0);
    chk_outs("haz_m_second_cycle", STALL);
    edge_step();
    chk_outs("stall_released", NONE);

    // No write in E, and x0 as destination, never stall.
    drive(1'b0, 5'd2, 5'd3, 5'd2, 5'd2, 1'b0);
    chk_outs("no_write_e", NONE);
    drive(1'b1, 5'd0, 5'd3, 5'd0, 5'd2, 1'b0);
    chk_outs("x0_dest_e", NONE);
    hif.regwriteE = 1'b0;
    hif.RdM = 'x;
    chk_outs("rdm_x_ignored", NONE);

    // Taken branch overrides stall, with and without a real hazard.
    drive(1'b0, 5'd2, 5'd2, 5'd2, 5'd0, 1'b1);
    chk_outs("branch_no_haz", FLUSH);
    hif.regwriteE = 1'b1;
    chk_outs("branch_with_haz_e", FLUSH);

    // Memory-only hazard: one stall cycle.
    drive(1'b1, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0);
    edge_step();
    drive(1'b0, 5'd5, 5'd3, 5'd9, 5'd5, 1'b0);
    chk_outs("haz_m_only", STALL);
    edge_step();
    chk_outs("haz_m_cleared", NONE);

    // Dual identical sources matching Memory destination.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0);
    edge_step();
    drive(1'b1, 5'd7, 5'd7, 5'd0, 5'd7, 1'b0);
    chk_outs("haz_m_dual_src", STALL);
    hif.PCSrcE = 1'b1;
    chk_outs("haz_m_branch", FLUSH);

    // Rs2-only matches, Memory and Execute.
    drive(1'b1, 5'd1, 5'd7, 5'd0, 5'd7, 1'b0);
    chk_outs("haz_m_rs2", STALL);
    drive(1'b1, 5'd1, 5'd4, 5'd4, 5'd0, 1'b0);
    chk_outs("haz_e_rs2", STALL);
    drive(1'b1, 5'd1, 5'd6, 5'd4, 5'd0, 1'b0);
    chk_outs("no_match", NONE);

    // Reset asserted mid-hazard silences everything combinationally.
    drive(1'b1, 5'd4, 5'd4, 5'd4, 5'd4, 1'b0);
    rst = 1'b1;
    chk_outs("rst_mid_hazard", NONE);
    edge_step();
    chk("rst_clears_regwriteM", 32'(dut.regwriteM_q), 32'd0);
    rst = 1'b0;
    drive(1'b0, 5'd4, 5'd4, 5'd0, 5'd4, 1'b0);
    chk_outs("after_rst_no_hazm", NONE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
